// File: rtl/axil_cmd_master_pkg.sv
// ----------------------------------------------------------------------------
// axil_pkg: shared types and constants for the AXI4-Lite command master.
//   - AXI4-Lite response codes
//   - FSM state enum
//   - latched command record (address field sized for the widest supported
//     ADDR_WIDTH; narrower configurations use the low bits only)
// ----------------------------------------------------------------------------
package axil_pkg;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXIL_RESP_DECERR = 2'b11;

    localparam int unsigned AXIL_ADDR_MAX = 32;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StWb,
        StRd,
        StRdr,
        StRsp
    } axil_state_e;

    typedef struct packed {
        logic                     write;
        logic [AXIL_ADDR_MAX-1:0] addr;
        logic [31:0]              wdata;
        logic [3:0]               wstrb;
    } axil_cmd_t;

endpackage

// File: rtl/axil_cmd_master_if.sv
// ----------------------------------------------------------------------------
// axil_cmd_master_if: AXI4-Lite bus (AR/R/AW/W/B channels).
//   master modport: drives arvalid/araddr/rready, awvalid/awaddr,
//                   wvalid/wdata/wstrb, bready
//   slave modport : drives arready, rvalid/rdata/rresp, awready, wready,
//                   bvalid/bresp
// Parameter ADDR_WIDTH sets araddr/awaddr width.
// ----------------------------------------------------------------------------
interface axil_cmd_master_if #(
    parameter int unsigned ADDR_WIDTH = 12
) ();

    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  rvalid;
    logic                  rready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;

    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    modport master (
        output arvalid, araddr, rready,
        output awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  arready, rvalid, rdata, rresp,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  arvalid, araddr, rready,
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
        output arready, rvalid, rdata, rresp,
        output awready, wready, bvalid, bresp
    );

endinterface

// File: rtl/axil_cmd_master.sv
// ----------------------------------------------------------------------------
// axil_cmd_master: AXI4-Lite initiator driven by a valid/ready command stream.
// Each command becomes one single-beat read or write; the result comes back
// on a valid/ready response stream. One transaction in flight at a time.
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (cmd_ready is combinational)
//   cmd_write              1 = write, 0 = read
//   cmd_addr               byte address, forwarded unchanged
//   cmd_wdata, cmd_wstrb   write data / strobes
//   rsp_valid/rsp_ready    response handshake
//   rsp_write              echo of cmd_write
//   rsp_rdata              read data (0 for writes)
//   rsp_resp               AXI response code from the slave
//   ctrl                   AXI4-Lite master port (axil_cmd_master_if.master)
//
// Parameters: ADDR_WIDTH (<= 32), TIMEOUT_CYCLES.
// Optional build macro AXIL_CMD_MASTER_TIMEOUT_EN: abort a transaction that
// waits TIMEOUT_CYCLES cycles on the slave and report DECERR. Without it the
// block waits indefinitely.
// ----------------------------------------------------------------------------
module axil_cmd_master
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,

    axil_cmd_master_if.master     ctrl
);

    axil_state_e state_q;
    axil_cmd_t   cmd_q;
    axil_cmd_t   cmd_in;

    logic        awvalid_q;
    logic        wvalid_q;
    logic        arvalid_q;
    logic        bready_q;
    logic        rready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic [1:0]  rsp_resp_q;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic b_hs;
    logic r_hs;
    logic aw_done;
    logic w_done;
    logic tmo_fire;

    // Pack the incoming command; address is zero-extended into the record.
    always_comb begin
        cmd_in                       = '0;
        cmd_in.write                 = cmd_write;
        cmd_in.addr[ADDR_WIDTH-1:0]  = cmd_addr;
        cmd_in.wdata                 = cmd_wdata;
        cmd_in.wstrb                 = cmd_wstrb;
    end

    assign aw_hs = awvalid_q & ctrl.awready;
    assign w_hs  = wvalid_q  & ctrl.wready;
    assign ar_hs = arvalid_q & ctrl.arready;
    assign b_hs  = bready_q  & ctrl.bvalid;
    assign r_hs  = rready_q  & ctrl.rvalid;

    // A write channel is finished if it already handshook or does so now.
    assign aw_done = ~awvalid_q | aw_hs;
    assign w_done  = ~wvalid_q  | w_hs;

    // Gated by aresetn so nothing is accepted while reset is held.
    assign cmd_ready = aresetn & (state_q == StIdle);

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES - 1);

    logic [TmoW-1:0] tmo_cnt_q;
    logic            waiting;
    logic            any_hs;

    assign waiting  = (state_q == StWr) | (state_q == StWb) |
                      (state_q == StRd) | (state_q == StRdr);
    assign any_hs   = aw_hs | w_hs | ar_hs | b_hs | r_hs;
    // A handshake landing in the expiry cycle takes priority over the abort.
    assign tmo_fire = waiting & (tmo_cnt_q == TmoMax) & ~any_hs;

    // Saturates at TmoMax so a partial write handshake on the last cycle
    // leaves the timeout armed for the next idle-bus cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tmo_cnt_q <= '0;
        end else if (state_q == StIdle) begin
            tmo_cnt_q <= '0;
        end else if (waiting && (tmo_cnt_q != TmoMax)) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

    // Upper address bits are constant zero when ADDR_WIDTH < 32.
    logic unused_cfg;
    assign unused_cfg = ^{cmd_q.addr, TIMEOUT_CYCLES};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= StIdle;
            cmd_q       <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        cmd_q <= cmd_in;
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= StWr;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= StRd;
                        end
                    end
                end
                StWr: begin
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs)  wvalid_q  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= StWb;
                    end
                end
                StWb: begin
                    if (ctrl.bvalid) begin
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_resp_q  <= ctrl.bresp;
                        state_q     <= StRsp;
                    end
                end
                StRd: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StRdr;
                    end
                end
                StRdr: begin
                    if (ctrl.rvalid) begin
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= ctrl.rdata;
                        rsp_resp_q  <= ctrl.rresp;
                        state_q     <= StRsp;
                    end
                end
                StRsp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Hung-bus recovery: withdraw every request and report DECERR.
            if (tmo_fire) begin
                awvalid_q   <= 1'b0;
                wvalid_q    <= 1'b0;
                arvalid_q   <= 1'b0;
                bready_q    <= 1'b0;
                rready_q    <= 1'b0;
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= '0;
                rsp_resp_q  <= AXIL_RESP_DECERR;
                state_q     <= StRsp;
            end
        end
    end

    assign ctrl.awvalid = awvalid_q;
    assign ctrl.awaddr  = cmd_q.addr[ADDR_WIDTH-1:0];
    assign ctrl.wvalid  = wvalid_q;
    assign ctrl.wdata   = cmd_q.wdata;
    assign ctrl.wstrb   = cmd_q.wstrb;
    assign ctrl.bready  = bready_q;
    assign ctrl.arvalid = arvalid_q;
    assign ctrl.araddr  = cmd_q.addr[ADDR_WIDTH-1:0];
    assign ctrl.rready  = rready_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_write = cmd_q.write;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// ----------------------------------------------------------------------------
// Bench for axil_cmd_master. Directed commands push their expected response
// into a queue; a monitor pops and compares on every rsp handshake. A simple
// AXI4-Lite slave model with configurable ready delays backs the bus.
// Timeout scenario only built with AXIL_CMD_MASTER_TIMEOUT_EN.
// ----------------------------------------------------------------------------
module tb_axil_cmd_master;
    import axil_pkg::*;

    localparam int unsigned AW = 12;

    typedef struct packed {
        logic        write;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } rsp_t;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [31:0]   cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic          rsp_write;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;

    int checks = 0;
    int errors = 0;
    rsp_t exp_q[$];

    axil_cmd_master_if #(.ADDR_WIDTH(AW)) ctrl_bus ();

    axil_cmd_master #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .ctrl      (ctrl_bus)
    );

    always #5 aclk = ~aclk;

    // ---------------- slave model ----------------
    int          aw_dly = 0;
    int          w_dly = 0;
    logic        ar_never = 1'b0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [1:0]  rresp_cfg = 2'b00;
    int          aw_cnt;
    int          w_cnt;
    int          b_count = 0;
    logic        aw_got;
    logic        w_got;
    logic [AW-1:0] aw_a;
    logic [31:0] w_d;
    logic [31:0] mem [16];

    logic aw_hs, w_hs, ar_hs;
    assign aw_hs = ctrl_bus.awvalid & ctrl_bus.awready;
    assign w_hs  = ctrl_bus.wvalid  & ctrl_bus.wready;
    assign ar_hs = ctrl_bus.arvalid & ctrl_bus.arready;

    function automatic logic [3:0] slv_idx(input logic [AW-1:0] a);
        return a[5:2];
    endfunction

    always_comb begin
        ctrl_bus.awready = ctrl_bus.awvalid && (aw_cnt >= aw_dly);
        ctrl_bus.wready  = ctrl_bus.wvalid  && (w_cnt  >= w_dly);
        ctrl_bus.arready = ctrl_bus.arvalid && !ar_never;
    end

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_cnt <= 0;
            w_cnt  <= 0;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            aw_a   <= '0;
            w_d    <= '0;
            ctrl_bus.bvalid <= 1'b0;
            ctrl_bus.bresp  <= 2'b00;
            ctrl_bus.rvalid <= 1'b0;
            ctrl_bus.rdata  <= '0;
            ctrl_bus.rresp  <= 2'b00;
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[0] <= 32'hDEADBEEF;
            mem[2] <= 32'h12345678;
        end else begin
            aw_cnt <= (ctrl_bus.awvalid && !ctrl_bus.awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (ctrl_bus.wvalid  && !ctrl_bus.wready)  ? w_cnt + 1  : 0;
            if (aw_hs) begin
                aw_got <= 1'b1;
                aw_a   <= ctrl_bus.awaddr;
            end
            if (w_hs) begin
                w_got <= 1'b1;
                w_d   <= ctrl_bus.wdata;
            end
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                ctrl_bus.bvalid <= 1'b1;
                ctrl_bus.bresp  <= bresp_cfg;
                b_count         <= b_count + 1;
                mem[slv_idx(aw_hs ? ctrl_bus.awaddr : aw_a)] <= w_hs ? ctrl_bus.wdata : w_d;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else if (ctrl_bus.bvalid && ctrl_bus.bready) begin
                ctrl_bus.bvalid <= 1'b0;
            end
            if (ar_hs) begin
                ctrl_bus.rvalid <= 1'b1;
                ctrl_bus.rdata  <= mem[slv_idx(ctrl_bus.araddr)];
                ctrl_bus.rresp  <= rresp_cfg;
            end else if (ctrl_bus.rvalid && ctrl_bus.rready) begin
                ctrl_bus.rvalid <= 1'b0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] outs_vec();
        return {26'd0, cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
                ctrl_bus.arvalid, ctrl_bus.araddr, ctrl_bus.rready,
                ctrl_bus.awvalid, ctrl_bus.awaddr, ctrl_bus.wvalid,
                ctrl_bus.wdata, ctrl_bus.wstrb, ctrl_bus.bready};
    endfunction

    // Called at a negedge; returns 1 ns after the accepting posedge.
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [3:0] s, input rsp_t e);
        int n;
        n = 0;
        exp_q.push_back(e);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        while (!cmd_ready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check("cmd_accept", cmd_ready, 1'b1);
        @(posedge aclk);
        #1;
        cmd_valid = 1'b0;
        cmd_wdata = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge aclk);
        while ((exp_q.size() != 0 || !cmd_ready) && n < 200) begin
            @(negedge aclk);
            n++;
        end
        check("txn_complete", (n < 200), 1'b1);
    endtask

    // ---------------- response monitor ----------------
    initial begin
        rsp_t e;
        forever begin
            @(negedge aclk);
            if (aresetn && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_payload", {rsp_write, rsp_rdata, rsp_resp}, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int b0;
        int seen;

        // Reset state
        repeat (3) @(negedge aclk);
        check("reset_outputs", outs_vec(), 128'd0);
        check("reset_cmd_ready", cmd_ready, 1'b0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("idle_cmd_ready", cmd_ready, 1'b1);

        // Zero-wait write: AW/W at N+1, rsp at N+3
        send(1'b1, 12'h004, 32'h0000_0002, 4'hF, '{1'b1, 32'h0, AXIL_RESP_OKAY});
        @(negedge aclk);
        check("wr_n1_valids", {ctrl_bus.awvalid, ctrl_bus.wvalid, ctrl_bus.bready, rsp_valid},
              4'b1100);
        check("wr_n1_payload", {ctrl_bus.awaddr, ctrl_bus.wdata, ctrl_bus.wstrb},
              {12'h004, 32'h0000_0002, 4'hF});
        @(negedge aclk);
        check("wr_n2_state", {ctrl_bus.awvalid, ctrl_bus.wvalid, ctrl_bus.bready, rsp_valid},
              4'b0010);
        @(negedge aclk);
        check("wr_n3_rsp_valid", rsp_valid, 1'b1);
        wait_idle();
        check("wr_slave_reg", mem[1], 32'h0000_0002);

        // Zero-wait read of 0x000
        send(1'b0, 12'h000, 32'h0, 4'h0, '{1'b0, 32'hDEADBEEF, AXIL_RESP_OKAY});
        @(negedge aclk);
        check("rd_n1_valids", {ctrl_bus.arvalid, ctrl_bus.rready, rsp_valid}, 3'b100);
        @(negedge aclk);
        check("rd_n2_valids", {ctrl_bus.arvalid, ctrl_bus.rready, rsp_valid}, 3'b010);
        @(negedge aclk);
        check("rd_n3_rsp_valid", rsp_valid, 1'b1);
        wait_idle();

        // W handshakes first, AW three cycles later
        aw_dly = 3;
        b0 = b_count;
        send(1'b1, 12'h00C, 32'hA5A5_0F0F, 4'h3, '{1'b1, 32'h0, AXIL_RESP_OKAY});
        @(negedge aclk);
        check("split_n1", {ctrl_bus.awvalid, ctrl_bus.wvalid, ctrl_bus.wstrb}, 6'b11_0011);
        for (int k = 2; k <= 4; k++) begin
            @(negedge aclk);
            check("split_aw_hold", {ctrl_bus.awvalid, ctrl_bus.wvalid, ctrl_bus.bready,
                                    ctrl_bus.awaddr}, {3'b100, 12'h00C});
        end
        @(negedge aclk);
        check("split_n5_wb", {ctrl_bus.awvalid, ctrl_bus.wvalid, ctrl_bus.bready, rsp_valid},
              4'b0010);
        @(negedge aclk);
        check("split_n6_rsp", rsp_valid, 1'b1);
        wait_idle();
        check("split_single_b", b_count - b0, 1);
        check("split_slave_reg", mem[3], 32'hA5A5_0F0F);
        aw_dly = 0;

        // SLVERR read with response back-pressure
        rresp_cfg = AXIL_RESP_SLVERR;
        rsp_ready = 1'b0;
        send(1'b0, 12'h008, 32'h0, 4'h0, '{1'b0, 32'h1234_5678, AXIL_RESP_SLVERR});
        @(negedge aclk);
        check("hold_araddr", {ctrl_bus.arvalid, ctrl_bus.araddr}, {1'b1, 12'h008});
        @(negedge aclk);
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            check("rsp_hold", {rsp_valid, cmd_ready, rsp_write, rsp_rdata, rsp_resp,
                               ctrl_bus.rready},
                  {1'b1, 1'b0, 1'b0, 32'h1234_5678, AXIL_RESP_SLVERR, 1'b0});
        end
        @(posedge aclk);
        #1;
        rsp_ready = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        check("idle_after_rsp", {cmd_ready, rsp_valid}, 2'b10);
        rresp_cfg = AXIL_RESP_OKAY;
        wait_idle();

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
        // Slave never raises arready: abort after 16 waiting cycles
        ar_never = 1'b1;
        send(1'b0, 12'h000, 32'h0, 4'h0, '{1'b0, 32'h0, AXIL_RESP_DECERR});
        repeat (16) @(negedge aclk);
        check("tmo_n16_waiting", {ctrl_bus.arvalid, rsp_valid}, 2'b10);
        @(negedge aclk);
        check("tmo_n17_abort", {ctrl_bus.arvalid, ctrl_bus.rready, rsp_valid}, 3'b001);
        wait_idle();
        ar_never = 1'b0;
        send(1'b0, 12'h004, 32'h0, 4'h0, '{1'b0, 32'h0000_0002, AXIL_RESP_OKAY});
        wait_idle();
`endif

        // Reset while wvalid is high
        aw_dly = 10;
        w_dly  = 10;
        send(1'b1, 12'h010, 32'h0000_0077, 4'hF, '{1'b1, 32'h0, AXIL_RESP_OKAY});
        @(negedge aclk);
        @(negedge aclk);
        check("rst_pre_wvalid", ctrl_bus.wvalid, 1'b1);
        #2;
        aresetn = 1'b0;
        #1;
        check("rst_async_outputs", outs_vec(), 128'd0);
        exp_q.delete();
        aw_dly = 0;
        w_dly  = 0;
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge aclk);
            if (rsp_valid) seen++;
        end
        check("no_rsp_after_reset", seen, 0);
        send(1'b0, 12'h008, 32'h0, 4'h0, '{1'b0, 32'h1234_5678, AXIL_RESP_OKAY});
        wait_idle();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
